axi_master_arbiter_r: RTL

AXI_MASTER_ARBITER_R -- requirements
Module: axi_master_arbiter_r

---
 rtl/axi_master_arbiter_r.sv | 119 +++++++++++
 1 files changed

// File: rtl/axi_master_arbiter_r.sv
// Round-robin read-address arbiter for two AXI masters. It owns the read mux grant from the
// winner's AR request until that burst's RLAST, and flags bursts whose beat count disagrees with ARLEN.
module axi_master_arbiter_r #(
    parameter int ID_WIDTH = 1
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                m0_ARVALID,
    input  logic                m1_ARVALID,
    input  logic [7:0]          m0_ARLEN,
    input  logic [7:0]          m1_ARLEN,
    input  logic                m_ARREADY,
    input  logic                m_RVALID,
    input  logic                m_RLAST,
    input  logic                s_RREADY,
    output logic                m0_rgrnt,
    output logic                m1_rgrnt,
    output logic                rlen_err,
    output logic                rbusy,
    output logic [1:0]          dbg_state,
    output logic                dbg_ptr,
    output logic [ID_WIDTH-1:0] dbg_owner
);

    // Handshakes: an AR transfer happens on a cycle where the granted master's ARVALID and
    // m_ARREADY are both high; a read beat happens on a cycle where m_RVALID and s_RREADY are both high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t     state, state_n;
    logic       ptr, ptr_n;
    logic       owner, owner_n;
    logic [7:0] cnt, cnt_n;
    logic       g0_n, g1_n, err_n, busy_n;
    logic       owner_valid;
    logic [7:0] owner_len;
    logic       beat;

    assign owner_valid = owner ? m1_ARVALID : m0_ARVALID;
    assign owner_len   = owner ? m1_ARLEN : m0_ARLEN;
    assign beat        = m_RVALID & s_RREADY;

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        cnt_n   = cnt;
        g0_n    = m0_rgrnt;
        g1_n    = m1_rgrnt;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                g0_n = 1'b0;
                g1_n = 1'b0;
                if (m0_ARVALID | m1_ARVALID) begin
                    // Preferred master wins a tie; a lone requester always wins.
                    owner_n = (m0_ARVALID & m1_ARVALID) ? ptr : m1_ARVALID;
                    g0_n    = ~owner_n;
                    g1_n    = owner_n;
                    state_n = ADDR;
                end
            end
            ADDR: begin
                if (owner_valid & m_ARREADY) begin
                    cnt_n   = owner_len;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (beat) begin
                    cnt_n = (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
                    err_n = m_RLAST ? (cnt != 8'd0) : (cnt == 8'd0);
                    if (m_RLAST) begin
                        g0_n    = 1'b0;
                        g1_n    = 1'b0;
                        ptr_n   = ~owner;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                g0_n    = 1'b0;
                g1_n    = 1'b0;
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            owner    <= 1'b0;
            cnt      <= 8'd0;
            m0_rgrnt <= 1'b0;
            m1_rgrnt <= 1'b0;
            rlen_err <= 1'b0;
            rbusy    <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            owner    <= owner_n;
            cnt      <= cnt_n;
            m0_rgrnt <= g0_n;
            m1_rgrnt <= g1_n;
            rlen_err <= err_n;
            rbusy    <= busy_n;
        end
    end

    assign dbg_state = state;
    assign dbg_ptr   = ptr;
    assign dbg_owner = ID_WIDTH'(owner);

endmodule
